// File: rtl/dec2c_entry.sv
// Decimal key-entry front end: accumulates typed digits and a sign into a signed
// 8-bit two's-complement value, committed on enter.
module dec2c_entry #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic       digit_ready,
  input  logic       sign_toggle,
  input  logic       clear,
  input  logic       enter,
  output logic [7:0] mag,
  output logic       neg,
  output logic [1:0] ndigits,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_MUL,
    S_ADD,
    S_ERR
  } state_t;

  localparam logic [1:0] LP_MAX_DIGITS = 2'(MAX_DIGITS);

  state_t      r_state;
  state_t      w_nextState;

  logic [7:0]  r_mag;
  logic        r_neg;
  logic [1:0]  r_ndigits;
  logic [10:0] r_acc;
  logic [3:0]  r_digit;
  logic [7:0]  r_value;
  logic        r_valueValid;

  logic        w_entryState;
  logic        w_accept;
  logic        w_doMul;
  logic        w_loadSum;
  logic        w_toggle;
  logic        w_commit;
  logic        w_clearAll;
  logic [10:0] w_sum;

  assign w_entryState = (r_state == S_IDLE) || (r_state == S_ENTRY);
  assign w_sum        = r_acc + {7'd0, r_digit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Event priority while accepting input: clear > enter > digit > sign_toggle.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_doMul     = 1'b0;
    w_loadSum   = 1'b0;
    w_toggle    = 1'b0;
    w_commit    = 1'b0;
    w_clearAll  = 1'b0;
    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (clear) begin
          w_clearAll  = 1'b1;
          w_nextState = S_IDLE;
        end else if (enter) begin
          if ((r_mag == 8'd128) && !r_neg) begin
            w_nextState = S_ERR;
          end else begin
            w_commit    = 1'b1;
            w_nextState = S_IDLE;
          end
        end else if (digit_valid) begin
          if ((digit > 4'd9) || (r_ndigits == LP_MAX_DIGITS)) begin
            w_nextState = S_ERR;
          end else begin
            w_accept    = 1'b1;
            w_nextState = S_MUL;
          end
        end else if (sign_toggle) begin
          w_toggle = 1'b1;
        end
      end
      S_MUL: begin
        if (clear) begin
          w_clearAll  = 1'b1;
          w_nextState = S_IDLE;
        end else begin
          w_doMul     = 1'b1;
          w_nextState = S_ADD;
        end
      end
      S_ADD: begin
        if (clear) begin
          w_clearAll  = 1'b1;
          w_nextState = S_IDLE;
        end else if (w_sum <= 11'd128) begin
          w_loadSum   = 1'b1;
          w_nextState = S_ENTRY;
        end else begin
          w_nextState = S_ERR;
        end
      end
      S_ERR: begin
        if (clear) begin
          w_clearAll  = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_clearAll  = 1'b1;
        w_nextState = S_IDLE;
      end
    endcase
  end

  // mag*10 is formed as mag*8 + mag*2 so no multiplier is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag        <= 8'd0;
      r_neg        <= 1'b0;
      r_ndigits    <= 2'd0;
      r_acc        <= 11'd0;
      r_digit      <= 4'd0;
      r_value      <= 8'd0;
      r_valueValid <= 1'b0;
    end else begin
      r_valueValid <= w_commit;
      if (w_clearAll) begin
        r_mag     <= 8'd0;
        r_neg     <= 1'b0;
        r_ndigits <= 2'd0;
        r_acc     <= 11'd0;
      end else if (w_commit) begin
        r_value   <= r_neg ? (~r_mag + 8'd1) : r_mag;
        r_mag     <= 8'd0;
        r_neg     <= 1'b0;
        r_ndigits <= 2'd0;
      end else begin
        if (w_accept) begin
          r_digit <= digit;
        end
        if (w_doMul) begin
          r_acc <= {r_mag, 3'b000} + {2'b00, r_mag, 1'b0};
        end
        if (w_loadSum) begin
          r_mag     <= w_sum[7:0];
          r_ndigits <= r_ndigits + 2'd1;
        end
        if (w_toggle) begin
          r_neg <= ~r_neg;
        end
      end
    end
  end

  assign digit_ready = w_entryState;
  assign mag         = r_mag;
  assign neg         = r_neg;
  assign ndigits     = r_ndigits;
  assign value       = r_value;
  assign value_valid = r_valueValid;
  assign err         = (r_state == S_ERR);

endmodule

// File: tb/tb_dec2c_entry.sv
// Directed self-checking bench for dec2c_entry with hand-computed expectations.
module tb_dec2c_entry;

  logic       clk;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       digit_ready;
  logic       sign_toggle;
  logic       clear;
  logic       enter;
  logic [7:0] mag;
  logic       neg;
  logic [1:0] ndigits;
  logic [7:0] value;
  logic       value_valid;
  logic       err;

  int testCount;
  int failCount;

  dec2c_entry #(.MAX_DIGITS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .sign_toggle (sign_toggle),
    .clear       (clear),
    .enter       (enter),
    .mag         (mag),
    .neg         (neg),
    .ndigits     (ndigits),
    .value       (value),
    .value_valid (value_valid),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later.
  task automatic applyStimulus(input logic dv, input logic [3:0] d, input logic st,
                               input logic clr, input logic ent);
    digit_valid = dv;
    digit       = d;
    sign_toggle = st;
    clear       = clr;
    enter       = ent;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    digit       = 4'd0;
    sign_toggle = 1'b0;
    clear       = 1'b0;
    enter       = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full digit entry: accept edge plus the MUL and ADD edges.
  task automatic typeDigit(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
  endtask

  initial begin
    testCount   = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
    sign_toggle = 1'b0;
    clear       = 1'b0;
    enter       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mag", 16'(mag), 16'h00);
    checkOutput("rst_neg", 16'(neg), 16'h0);
    checkOutput("rst_ndigits", 16'(ndigits), 16'h0);
    checkOutput("rst_value", 16'(value), 16'h00);
    checkOutput("rst_vvalid", 16'(value_valid), 16'h0);
    checkOutput("rst_err", 16'(err), 16'h0);
    checkOutput("rst_ready", 16'(digit_ready), 16'h1);
    rst_n = 1'b1;

    // "127" enter, with the two-cycle ready gap checked on the first digit
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("ready_mul", 16'(digit_ready), 16'h0);
    idleCycle();
    checkOutput("ready_add", 16'(digit_ready), 16'h0);
    idleCycle();
    checkOutput("ready_back", 16'(digit_ready), 16'h1);
    checkOutput("mag_1", 16'(mag), 16'd1);
    typeDigit(4'd2);
    checkOutput("mag_12", 16'(mag), 16'd12);
    typeDigit(4'd7);
    checkOutput("mag_127", 16'(mag), 16'd127);
    checkOutput("ndig_3", 16'(ndigits), 16'd3);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("value_7f", 16'(value), 16'h7F);
    checkOutput("vvalid_pulse", 16'(value_valid), 16'h1);
    checkOutput("mag_cleared", 16'(mag), 16'h00);
    checkOutput("ndig_cleared", 16'(ndigits), 16'h0);
    idleCycle();
    checkOutput("vvalid_low", 16'(value_valid), 16'h0);
    checkOutput("value_hold", 16'(value), 16'h7F);

    // "-128"
    typeDigit(4'd1);
    typeDigit(4'd2);
    typeDigit(4'd8);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("neg_set", 16'(neg), 16'h1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("value_80", 16'(value), 16'h80);
    checkOutput("vvalid_80", 16'(value_valid), 16'h1);
    checkOutput("neg_cleared", 16'(neg), 16'h0);

    // "+128" enter must fail without committing
    typeDigit(4'd1);
    typeDigit(4'd2);
    typeDigit(4'd8);
    checkOutput("mag_128", 16'(mag), 16'd128);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("err_p128", 16'(err), 16'h1);
    checkOutput("vvalid_p128", 16'(value_valid), 16'h0);
    checkOutput("value_p128", 16'(value), 16'h80);
    checkOutput("ready_err", 16'(digit_ready), 16'h0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("err_clr", 16'(err), 16'h0);
    checkOutput("mag_clr", 16'(mag), 16'h00);
    checkOutput("ready_clr", 16'(digit_ready), 16'h1);

    // "200" overflows at the third ADD, mag holds 20
    typeDigit(4'd2);
    typeDigit(4'd0);
    checkOutput("mag_20", 16'(mag), 16'd20);
    typeDigit(4'd0);
    checkOutput("err_200", 16'(err), 16'h1);
    checkOutput("mag_hold20", 16'(mag), 16'd20);
    checkOutput("ndig_hold2", 16'(ndigits), 16'd2);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // illegal digit 10
    applyStimulus(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
    checkOutput("err_digit10", 16'(err), 16'h1);
    checkOutput("mag_digit10", 16'(mag), 16'h00);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // "007" then a fourth digit
    typeDigit(4'd0);
    typeDigit(4'd0);
    typeDigit(4'd7);
    checkOutput("mag_007", 16'(mag), 16'd7);
    checkOutput("ndig_007", 16'(ndigits), 16'd3);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("err_4th", 16'(err), 16'h1);
    checkOutput("mag_4th", 16'(mag), 16'd7);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // digit_valid held high with digit 5: accept, gap, gap, accept, gap, gap
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("thr_r0", 16'(digit_ready), 16'h0);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("thr_r1", 16'(digit_ready), 16'h0);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("thr_r2", 16'(digit_ready), 16'h1);
    checkOutput("thr_mag5", 16'(mag), 16'd5);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("thr_r3", 16'(digit_ready), 16'h0);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("thr_r4", 16'(digit_ready), 16'h0);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("thr_r5", 16'(digit_ready), 16'h1);
    checkOutput("thr_mag55", 16'(mag), 16'd55);
    checkOutput("thr_ndig2", 16'(ndigits), 16'd2);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // clear beats enter in the same cycle
    typeDigit(4'd3);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("clrent_vvalid", 16'(value_valid), 16'h0);
    checkOutput("clrent_mag", 16'(mag), 16'h00);
    checkOutput("clrent_ready", 16'(digit_ready), 16'h1);
    checkOutput("clrent_value", 16'(value), 16'h80);

    // enter in IDLE commits zero
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("idle_value", 16'(value), 16'h00);
    checkOutput("idle_vvalid", 16'(value_valid), 16'h1);

    // enter beats a same-cycle digit
    typeDigit(4'd4);
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
    checkOutput("entdig_value", 16'(value), 16'h04);
    checkOutput("entdig_vvalid", 16'(value_valid), 16'h1);
    checkOutput("entdig_ready", 16'(digit_ready), 16'h1);
    checkOutput("entdig_mag", 16'(mag), 16'h00);

    // asynchronous reset in the MUL cycle of the second digit
    typeDigit(4'd4);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_mag", 16'(mag), 16'h00);
    checkOutput("arst_ndig", 16'(ndigits), 16'h0);
    checkOutput("arst_value", 16'(value), 16'h00);
    checkOutput("arst_vvalid", 16'(value_valid), 16'h0);
    checkOutput("arst_ready", 16'(digit_ready), 16'h1);
    rst_n = 1'b1;
    typeDigit(4'd4);
    typeDigit(4'd5);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("post_rst_2d", 16'(value), 16'h2D);
    checkOutput("post_rst_vv", 16'(value_valid), 16'h1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
